mem_resp_stage: RTL and testbench

- Memory-stage producer of the ms_to_ws valid/allowin handshake feeding the writeback stage.
- Accepts the EX-stage bundle and waits for the SRAM-like data_sram read response (data_ok/rdata) for loads issued in EX.
- Extracts and extends load data, then presents the 121-bit ms_to_ws bundle.
- Buffers responses that arrive while WB stalls, and discards the response of a load killed by ws_flush.

---
 rtl/mem_resp_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_resp_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_stage.sv
// MEM stage: holds the EX bundle, waits for the data_sram response, extends load data and presents the bundle to WB.
// Optional define MS_FWD_EN enables forwarding of the MEM result to decode via ms_to_ds_bus.
//
// state  | meaning
// S_IDLE | no response outstanding for the current instruction
// S_WAIT | current instruction waits for its data_ok
// S_BUF  | response captured in buffer, WB has not accepted yet
// S_DROP | response of a flushed instruction still due; next data_ok is ignored
module mem_resp_stage #(
   parameter int ES_TO_MS_BUS_WD = 126,
   parameter int MS_TO_WS_BUS_WD = 121
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_allowin,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   input  logic                       ws_allowin,
   input  logic                       ws_flush,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [38:0]                ms_to_ds_bus,
   output logic                       ms_block
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUF, S_DROP} state_t;

   state_t                     state;
   logic                       ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
   logic [31:0]                buffer;

   logic        mem_req_sent;
   logic        load_op;
   logic [2:0]  ld_type;
   logic        ex;
   logic        eret;
   logic        tlb_flush;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] pay_result;

   assign mem_req_sent = es_bus_r[125];
   assign load_op      = es_bus_r[124];
   assign ld_type      = es_bus_r[123:121];
   assign tlb_flush    = es_bus_r[119];
   assign ex           = es_bus_r[115];
   assign eret         = es_bus_r[114];
   assign gr_we        = es_bus_r[69];
   assign dest         = es_bus_r[68:64];
   assign pay_result   = es_bus_r[63:32];

   logic buf_valid;
   logic discard;
   logic wait_data;
   logic ms_ready_go;
   logic load_en;
   logic new_wait;

   assign buf_valid      = (state == S_BUF);
   assign discard        = (state == S_DROP);
   assign wait_data      = ms_valid && mem_req_sent && !ex;
   assign ms_ready_go    = !wait_data || buf_valid || (data_sram_data_ok && !discard);
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;
   assign load_en        = es_to_ms_valid && ms_allowin && !ws_flush;
   assign new_wait       = es_to_ms_bus[125] && !es_to_ms_bus[115];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid <= 1'b0;
         es_bus_r <= '0;
      end else begin
         if (ws_flush) begin
            ms_valid <= 1'b0;
         end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
         end
         if (es_to_ms_valid && ms_allowin) begin
            es_bus_r <= es_to_ms_bus;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= S_IDLE;
         buffer <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (load_en && new_wait) state <= S_WAIT;
            end
            S_WAIT: begin
               // a response arriving with the flush belongs to the flushed load, nothing left to drop
               if (ws_flush) begin
                  state <= data_sram_data_ok ? S_IDLE : S_DROP;
               end else if (data_sram_data_ok && !ws_allowin) begin
                  state  <= S_BUF;
                  buffer <= data_sram_rdata;
               end else if (data_sram_data_ok) begin
                  state <= (load_en && new_wait) ? S_WAIT : S_IDLE;
               end
            end
            S_BUF: begin
               if (ws_flush) begin
                  state  <= S_IDLE;
                  buffer <= '0;
               end else if (ws_allowin) begin
                  state  <= (load_en && new_wait) ? S_WAIT : S_IDLE;
                  buffer <= '0;
               end
            end
            S_DROP: begin
               if (data_sram_data_ok) begin
                  if (ws_flush) begin
                     state <= wait_data ? S_DROP : S_IDLE;
                  end else if (wait_data || (load_en && new_wait)) begin
                     state <= S_WAIT;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   logic [31:0] ld_src;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] ms_result;

   always_comb begin
      ld_src  = buf_valid ? buffer : data_sram_rdata;
      ld_half = pay_result[1] ? ld_src[31:16] : ld_src[15:0];
      case (pay_result[1:0])
         2'd0:    ld_byte = ld_src[7:0];
         2'd1:    ld_byte = ld_src[15:8];
         2'd2:    ld_byte = ld_src[23:16];
         default: ld_byte = ld_src[31:24];
      endcase
      case (ld_type)
         3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'd2:    ld_data = {24'd0, ld_byte};
         3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
         3'd4:    ld_data = {16'd0, ld_half};
         default: ld_data = ld_src;
      endcase
      ms_result = (load_op && !ex) ? ld_data : pay_result;
   end

   assign ms_to_ws_bus = {es_bus_r[120:64], ms_result, es_bus_r[31:0]};
   assign ms_block     = ms_valid && (ex || eret || tlb_flush);

   logic        rf_we;
   logic        wdata_valid;
   logic [31:0] wdata;

   assign rf_we = ms_valid && gr_we && !ex;
`ifdef MS_FWD_EN
   // mfc0 reads CP0 in WB, so its MEM result is not the final value
   assign wdata_valid = ms_to_ws_valid && !es_bus_r[113];
   assign wdata       = ms_result;
`else
   assign wdata_valid = 1'b0;
   assign wdata       = '0;
`endif

   assign ms_to_ds_bus = {rf_we, wdata_valid, dest, wdata};

endmodule

// File: tb/tb_mem_resp_stage.sv
// Self-checking bench for mem_resp_stage: load-extension table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_resp_stage;

   logic         clk;
   logic         resetn;
   logic         es_to_ms_valid;
   logic [125:0] es_to_ms_bus;
   logic         ms_allowin;
   logic         data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic         ws_allowin;
   logic         ws_flush;
   logic         ms_to_ws_valid;
   logic [120:0] ms_to_ws_bus;
   logic [38:0]  ms_to_ds_bus;
   logic         ms_block;

   int checks = 0;
   int errors = 0;

   mem_resp_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ms_allowin        (ms_allowin),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ws_allowin        (ws_allowin),
      .ws_flush          (ws_flush),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ms_to_ds_bus      (ms_to_ds_bus),
      .ms_block          (ms_block)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  ldt;
      logic [31:0] addr;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      es_to_ms_valid    = 1'b0;
      es_to_ms_bus      = '0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = '0;
      ws_allowin        = 1'b1;
      ws_flush          = 1'b0;
   endtask

   function automatic logic [125:0] mk(input logic req, input logic load, input logic [2:0] ldt,
                                       input logic ex, input logic eret, input logic mfc0,
                                       input logic grwe, input logic [4:0] dest,
                                       input logic [31:0] result, input logic [31:0] pc);
      logic [125:0] b;
      b          = '0;
      b[125]     = req;
      b[124]     = load;
      b[123:121] = ldt;
      b[115]     = ex;
      b[114]     = eret;
      b[113]     = mfc0;
      b[69]      = grwe;
      b[68:64]   = dest;
      b[63:32]   = result;
      b[31:0]    = pc;
      return b;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * a)) & 32'h0000_00FF;
      h = (w >> (16 * a[1])) & 32'h0000_FFFF;
      case (t)
         3'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
         3'd2:    return b;
         3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd4:    return h;
         default: return w;
      endcase
   endfunction

   // reference model state
   logic         m_valid;
   logic [125:0] m_bus;
   logic         m_have;
   logic [31:0]  m_data;
   int           m_stale;
   logic         need, arrived, ready, e_allowin, e_valid, e_rfwe, e_block;
   logic [31:0]  src, e_res;
   logic [120:0] e_wsbus;
   logic [38:0]  e_ds;
   logic [127:0] r128;

   initial begin
      vecs[0]  = '{3'd1, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80};
      vecs[1]  = '{3'd2, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080};
      vecs[2]  = '{3'd1, 32'h0000_2000, 32'h80FF_1234, 32'h0000_0034};
      vecs[3]  = '{3'd1, 32'h0000_2001, 32'h80FF_1234, 32'h0000_0012};
      vecs[4]  = '{3'd1, 32'h0000_2002, 32'h80FF_1234, 32'hFFFF_FFFF};
      vecs[5]  = '{3'd2, 32'h0000_2002, 32'h80FF_1234, 32'h0000_00FF};
      vecs[6]  = '{3'd3, 32'h0000_3000, 32'hBEEF_8001, 32'hFFFF_8001};
      vecs[7]  = '{3'd3, 32'h0000_3002, 32'hBEEF_8001, 32'hFFFF_BEEF};
      vecs[8]  = '{3'd4, 32'h0000_3002, 32'hBEEF_8001, 32'h0000_BEEF};
      vecs[9]  = '{3'd0, 32'h0000_4000, 32'h1234_5678, 32'h1234_5678};
      vecs[10] = '{3'd6, 32'h0000_4001, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vecs[11] = '{3'd5, 32'h0000_4003, 32'h8765_4321, 32'h8765_4321};

      idle_in();
      resetn = 1'b0;
      #12;
      chk("rst_allowin", 128'(ms_allowin), 128'(1'b1));
      chk("rst_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      chk("rst_ws_bus", 128'(ms_to_ws_bus), 128'(0));
      chk("rst_ds_bus", 128'(ms_to_ds_bus), 128'(0));
      chk("rst_block", 128'(ms_block), 128'(1'b0));
      resetn = 1'b1;
      tick();

      // load extension table: data_ok two cycles after entry
      for (int i = 0; i < 12; i++) begin
         idle_in();
         es_to_ms_valid = 1'b1;
         es_to_ms_bus   = mk(1'b1, 1'b1, vecs[i].ldt, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, vecs[i].addr, 32'h100);
         tick();
         es_to_ms_valid = 1'b0;
         #2;
         chk("tbl_wait_valid", 128'(ms_to_ws_valid), 128'(1'b0));
         chk("tbl_wait_allowin", 128'(ms_allowin), 128'(1'b0));
         tick();
         data_sram_data_ok = 1'b1;
         data_sram_rdata   = vecs[i].rdata;
         #2;
         chk("tbl_valid", 128'(ms_to_ws_valid), 128'(1'b1));
         chk("tbl_result", 128'(ms_to_ws_bus[63:32]), 128'(vecs[i].exp));
         tick();
         data_sram_data_ok = 1'b0;
         data_sram_rdata   = 32'h5555_5555;
         #2;
         chk("tbl_after_valid", 128'(ms_to_ws_valid), 128'(1'b0));
         tick();
      end

      // lhu buffered while WB stalls
      idle_in();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0002, 32'h200);
      tick();
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hBEEF_0001;
      ws_allowin        = 1'b0;
      #2;
      chk("buf_first_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      chk("buf_first_result", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_BEEF));
      chk("buf_first_allowin", 128'(ms_allowin), 128'(1'b0));
      tick();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h1111_1111;
      for (int k = 0; k < 2; k++) begin
         #2;
         chk("buf_hold_valid", 128'(ms_to_ws_valid), 128'(1'b1));
         chk("buf_hold_result", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_BEEF));
         chk("buf_hold_allowin", 128'(ms_allowin), 128'(1'b0));
         tick();
      end
      ws_allowin = 1'b1;
      #2;
      chk("buf_accept_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      chk("buf_accept_result", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_BEEF));
      chk("buf_accept_allowin", 128'(ms_allowin), 128'(1'b1));
      tick();
      #2;
      chk("buf_gone_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      tick();

      // flush while waiting, stale response must be dropped
      idle_in();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0100, 32'h300);
      tick();
      es_to_ms_valid = 1'b0;
      ws_flush       = 1'b1;
      tick();
      ws_flush       = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0200, 32'h304);
      #2;
      chk("flush_allowin", 128'(ms_allowin), 128'(1'b1));
      chk("flush_valid", 128'(ms_to_ws_valid), 128'(1'b0));
      tick();
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hDEAD_BEEF;
      #2;
      chk("stale_ignored", 128'(ms_to_ws_valid), 128'(1'b0));
      tick();
      data_sram_rdata = 32'h1234_5678;
      #2;
      chk("new_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      chk("new_result", 128'(ms_to_ws_bus[63:32]), 128'(32'h1234_5678));
      tick();
      data_sram_data_ok = 1'b0;
      #2;
      chk("new_gone", 128'(ms_to_ws_valid), 128'(1'b0));
      tick();

      // excepting instruction with a memory request does not wait
      idle_in();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0044, 32'h400);
      tick();
      es_to_ms_valid = 1'b0;
      #2;
      chk("ex_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      chk("ex_block", 128'(ms_block), 128'(1'b1));
      chk("ex_rf_we", 128'(ms_to_ds_bus[38]), 128'(1'b0));
      chk("ex_result", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_0044));
      tick();

      // store waits for data_ok, result unchanged
      idle_in();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_1003, 32'h500);
      tick();
      es_to_ms_valid = 1'b0;
      #2;
      chk("st_wait", 128'(ms_to_ws_valid), 128'(1'b0));
      tick();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hFFFF_FFFF;
      #2;
      chk("st_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      chk("st_result", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_1003));
      tick();

      // forwarding: ALU result and mfc0
      idle_in();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd7, 32'h600);
      tick();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h33, 32'h604);
      #2;
`ifdef MS_FWD_EN
      chk("fwd_alu", 128'(ms_to_ds_bus), 128'({1'b1, 1'b1, 5'd5, 32'd7}));
`else
      chk("fwd_alu", 128'(ms_to_ds_bus), 128'({1'b1, 1'b0, 5'd5, 32'd0}));
`endif
      tick();
      es_to_ms_valid = 1'b0;
      #2;
      chk("mfc0_wdata_valid", 128'(ms_to_ds_bus[37]), 128'(1'b0));
      chk("mfc0_rf_we", 128'(ms_to_ds_bus[38]), 128'(1'b1));
      tick();

      // asynchronous reset in the middle of a buffered response
      idle_in();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0000_0700, 32'h700);
      tick();
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hA5A5_0F0F;
      ws_allowin        = 1'b0;
      tick();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = '0;
      #2;
      chk("rbuf_valid", 128'(ms_to_ws_valid), 128'(1'b1));
      #1 resetn = 1'b0;
      #1;
      chk("rbuf_valid_drop", 128'(ms_to_ws_valid), 128'(1'b0));
      chk("rbuf_allowin", 128'(ms_allowin), 128'(1'b1));
      chk("rbuf_bus", 128'(ms_to_ws_bus), 128'(0));
      #1 resetn = 1'b1;
      tick();
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0000_0800, 32'h704);
      tick();
      es_to_ms_valid = 1'b0;
      #2;
      chk("rbuf_cleared", 128'(ms_to_ws_valid), 128'(1'b0));
      tick();

      // randomized run against the reference model
      idle_in();
      resetn = 1'b0;
      #3 resetn = 1'b1;
      tick();
      m_valid = 1'b0;
      m_bus   = '0;
      m_have  = 1'b0;
      m_data  = '0;
      m_stale = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         need = m_valid && m_bus[125] && !m_bus[115];
         es_to_ms_valid = ($urandom_range(0, 2) != 0);
         r128 = {$urandom, $urandom, $urandom, $urandom};
         es_to_ms_bus = r128[125:0];
         es_to_ms_bus[115] = ($urandom_range(0, 7) == 0);
         data_sram_data_ok = ((m_stale > 0) || (need && !m_have)) && ($urandom_range(0, 2) == 0);
         data_sram_rdata   = $urandom;
         ws_allowin        = ($urandom_range(0, 3) != 0);
         ws_flush          = (m_stale == 0) && ($urandom_range(0, 15) == 0);
         #2;
         arrived   = data_sram_data_ok && (m_stale == 0);
         ready     = !need || m_have || arrived;
         e_allowin = !m_valid || (ready && ws_allowin);
         e_valid   = m_valid && ready;
         src       = m_have ? m_data : data_sram_rdata;
         e_res     = (m_bus[124] && !m_bus[115]) ? ref_load(m_bus[123:121], m_bus[33:32], src) : m_bus[63:32];
         e_wsbus   = {m_bus[120:64], e_res, m_bus[31:0]};
         e_rfwe    = m_valid && m_bus[69] && !m_bus[115];
`ifdef MS_FWD_EN
         e_ds      = {e_rfwe, e_valid && !m_bus[113], m_bus[68:64], e_res};
`else
         e_ds      = {e_rfwe, 1'b0, m_bus[68:64], 32'd0};
`endif
         e_block   = m_valid && (m_bus[115] || m_bus[114] || m_bus[119]);
         chk("rnd_allowin", 128'(ms_allowin), 128'(e_allowin));
         chk("rnd_valid", 128'(ms_to_ws_valid), 128'(e_valid));
         chk("rnd_ws_bus", 128'(ms_to_ws_bus), 128'(e_wsbus));
         chk("rnd_ds_bus", 128'(ms_to_ds_bus), 128'(e_ds));
         chk("rnd_block", 128'(ms_block), 128'(e_block));
         if (ws_flush) begin
            if (need && !m_have && !arrived) m_stale++;
            m_have = 1'b0;
         end else begin
            if (data_sram_data_ok && m_stale > 0) m_stale--;
            if (need && !m_have && arrived && !ws_allowin) begin
               m_have = 1'b1;
               m_data = data_sram_rdata;
            end
         end
         if (e_allowin) m_have = 1'b0;
         if (es_to_ms_valid && e_allowin) m_bus = es_to_ms_bus;
         if (ws_flush) m_valid = 1'b0;
         else if (e_allowin) m_valid = es_to_ms_valid;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
